run_ctrl: RTL and testbench

Run controller that sequences one program execution of the core.
- Turns a host Start request into a clean core reset, then a run window.
- Watches the core's Done (halt) flag and returns a held Ack.
- Counts executed cycles, captures the final program counter, and aborts runaway programs with a watchdog.
- Sits between the bench/host Start/Ack pins and the core's reset/enable inputs inside the top level.

---
 rtl/run_ctrl.sv | 100 ++++++++++
 tb/tb_run_ctrl.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/run_ctrl.sv
// run_ctrl: sequences one program execution of the core.
//   A rising edge on Start puts the core into reset for RST_CYCLES cycles.
//   The controller then enables the core (RUN) until the core raises Done or
//   the watchdog expires. Ack, Timeout, CycleCnt and LastPC hold the result
//   until the next launch. Core outputs are decoded from state only, so there
//   is no combinational path from Start to any output.
// Ports:
//   Clk, Reset         clock, synchronous active-high reset
//   Start              host launch request (level; rising edge launches)
//   Done, ProgCtr      core halt flag and program counter
//   CoreReset, CoreEn  core reset / run enable
//   Ack, Timeout       run finished / watchdog fired (held)
//   CycleCnt, LastPC   RUN cycle count and final PC of the last run
module run_ctrl #(
  parameter int          CYCLE_W    = 16,
  parameter int          PC_W       = 10,
  parameter int          RST_CYCLES = 2,
  parameter int unsigned TIMEOUT    = 50000
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Start,
  input  logic               Done,
  input  logic [PC_W-1:0]    ProgCtr,
  output logic               CoreReset,
  output logic               CoreEn,
  output logic               Ack,
  output logic               Timeout,
  output logic [CYCLE_W-1:0] CycleCnt,
  output logic [PC_W-1:0]    LastPC
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_INIT  = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_FAULT = 3'd4;

  localparam int IW = $clog2(RST_CYCLES + 1);
  localparam logic [IW-1:0]      INIT_LD = IW'(RST_CYCLES);
  localparam logic [CYCLE_W-1:0] TO      = CYCLE_W'(TIMEOUT);
  // Watchdog compares against TO-1 so the firing edge lands CycleCnt on TO.
  localparam logic [CYCLE_W-1:0] TO_M1   = TO - 1'b1;

  logic [2:0]    state;
  logic          start_q;
  logic [IW-1:0] init_cnt;
  logic          launch;

  assign launch    = Start & ~start_q;
  assign CoreReset = (state == S_IDLE) || (state == S_INIT);
  assign CoreEn    = (state == S_RUN);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= S_IDLE;
      start_q  <= 1'b0;
      init_cnt <= '0;
      Ack      <= 1'b0;
      Timeout  <= 1'b0;
      CycleCnt <= '0;
      LastPC   <= '0;
    end else begin
      start_q <= Start;
      case (state)
        S_IDLE, S_DONE, S_FAULT: begin
          if (launch) begin
            state    <= S_INIT;
            init_cnt <= INIT_LD;
            CycleCnt <= '0;
            Ack      <= 1'b0;
            Timeout  <= 1'b0;
          end
        end
        S_INIT: begin
          // Loaded with RST_CYCLES, leaves on the edge where it hits zero,
          // so INIT (core reset) lasts exactly RST_CYCLES cycles.
          init_cnt <= init_cnt - 1'b1;
          if (init_cnt == IW'(1)) state <= S_RUN;
        end
        S_RUN: begin
          // Saturating count; only reachable with the watchdog disabled.
          if (CycleCnt != '1) CycleCnt <= CycleCnt + 1'b1;
          if (Done) begin
            state  <= S_DONE;
            LastPC <= ProgCtr;
            Ack    <= 1'b1;
          end else if ((TO != '0) && (CycleCnt == TO_M1)) begin
            state   <= S_FAULT;
            LastPC  <= ProgCtr;
            Ack     <= 1'b1;
            Timeout <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_run_ctrl.sv
module tb_run_ctrl;
  localparam int RST = 2;
  localparam int TO  = 8;

  logic       Clk = 0, Reset = 1, Start = 0, Done = 0;
  logic [9:0] ProgCtr = '0;
  logic       CoreReset, CoreEn, Ack, Timeout;
  logic [15:0] CycleCnt;
  logic [9:0]  LastPC;

  run_ctrl #(.CYCLE_W(16), .PC_W(10), .RST_CYCLES(RST), .TIMEOUT(TO)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Done(Done), .ProgCtr(ProgCtr),
    .CoreReset(CoreReset), .CoreEn(CoreEn), .Ack(Ack), .Timeout(Timeout),
    .CycleCnt(CycleCnt), .LastPC(LastPC));

  always #5 Clk = ~Clk;

  typedef struct {
    bit to;
    int cnt;
    int pc;
    int en;
    int rst;   // expected core-reset length, -1 when launched from IDLE
  } exp_t;

  exp_t q[$];
  int checks = 0, errors = 0;
  bit from_idle = 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clk); #1;
  endtask

  // Reference: a run whose Done arrives in RUN cycle n ends after min(n,TO)
  // RUN cycles; it is a watchdog fault only when n exceeds TO.
  task automatic do_run(input int n, input int slen, input bit abuse, input logic [9:0] pc);
    int endc, lim, mx;
    exp_t e;
    endc = (n <= TO) ? n : TO;
    e.to = (n > TO); e.cnt = endc; e.pc = pc; e.en = endc;
    e.rst = from_idle ? -1 : RST;
    q.push_back(e);
    from_idle = 0;
    Start = 1; Done = 1'($urandom); ProgCtr = 10'($urandom);
    tick();  // launch edge
    chk("launch_ack", Ack, 0);
    chk("launch_cnt", CycleCnt, 0);
    chk("launch_to", Timeout, 0);
    chk("launch_crst", CoreReset, 1);
    chk("launch_en", CoreEn, 0);
    mx = (endc > slen) ? endc : slen;
    lim = RST + mx + 1;
    for (int ed = 1; ed <= lim; ed++) begin
      Start   = (ed < slen) || (abuse && ed == RST + 2);
      Done    = (ed <= RST) ? 1'($urandom) : (ed == RST + n);
      ProgCtr = (ed == RST + endc) ? pc : 10'($urandom);
      tick();
    end
    Start = 0; Done = 0;
    tick(); tick();
    for (int w = 0; w < 20 && q.size() != 0; w++) tick();
    chk("ack_seen", q.size(), 0);
    q.delete();
  endtask

  // Monitor: pops an expectation on each Ack rise and checks holds after.
  exp_t cur;
  bit have_cur = 0, p_rst = 0, p_en = 0, p_ack = 0;
  int en_len = 0, rst_len = 0, rst_seen = -1;

  always @(negedge Clk) begin
    if (Reset) begin
      en_len = 0; rst_len = 0; rst_seen = -1; have_cur = 0;
    end else begin
      if (CoreReset && !p_rst) rst_len = 0;
      if (CoreReset) rst_len++;
      if (CoreEn && !p_en) begin en_len = 0; rst_seen = rst_len; end
      if (CoreEn) en_len++;
      if (Ack && !p_ack) begin
        if (q.size() == 0) begin
          chk("unexpected_ack", 1, 0);
        end else begin
          cur = q.pop_front();
          have_cur = 1;
          chk("res_timeout", Timeout, cur.to);
          chk("res_cyclecnt", CycleCnt, cur.cnt);
          chk("res_lastpc", LastPC, cur.pc);
          chk("res_en_len", en_len, cur.en);
          if (cur.rst >= 0) chk("res_crst_len", rst_seen, cur.rst);
        end
      end else if (Ack && have_cur) begin
        chk("hold_cnt", CycleCnt, cur.cnt);
        chk("hold_pc", LastPC, cur.pc);
        chk("hold_to", Timeout, cur.to);
        chk("hold_en", CoreEn, 0);
        chk("hold_crst", CoreReset, 0);
      end
    end
    p_rst = CoreReset; p_en = CoreEn; p_ack = Ack;
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_crst"}, CoreReset, 1);
    chk({tag, "_en"}, CoreEn, 0);
    chk({tag, "_ack"}, Ack, 0);
    chk({tag, "_to"}, Timeout, 0);
    chk({tag, "_cnt"}, CycleCnt, 0);
    chk({tag, "_pc"}, LastPC, 0);
  endtask

  initial begin
    int n, sl;
    bit ab;
    Reset = 1;
    tick(); chk_reset_vals("rst1");
    tick(); chk_reset_vals("rst2");
    Reset = 0;
    tick(); chk_reset_vals("idle");

    do_run(5, 1, 0, 10'd37);     // normal run
    repeat (20) tick();          // result must hold
    do_run(7, 1, 0, 10'd99);     // relaunch from DONE
    do_run(20, 1, 0, 10'd12);    // watchdog fires
    do_run(TO, 1, 0, 10'd12);    // Done on the watchdog edge wins
    do_run(6, 10, 0, 10'd200);   // Start held 10 cycles
    do_run(2, 10, 0, 10'd201);   // Start still high after the run ends
    do_run(7, 1, 1, 10'd300);    // extra Start pulse during RUN

    for (int i = 0; i < 12; i++) begin
      n  = $urandom_range(1, 12);
      sl = $urandom_range(1, 4);
      ab = (sl == 1 && n >= 2) ? 1'($urandom) : 1'b0;
      do_run(n, sl, ab, 10'($urandom));
    end

    // Reset in RUN cycle 3
    Start = 1; tick(); Start = 0;
    repeat (RST + 2) tick();
    chk("mid_en", CoreEn, 1);
    Reset = 1; tick(); Reset = 0;
    chk_reset_vals("midrst");
    from_idle = 1;
    tick();
    do_run(4, 1, 0, 10'd555);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL time_limit actual=%0t expected=<200000", $time);
    $fatal(1, "time limit");
  end
endmodule
